// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs one registered request/acknowledge bus
// transaction per aligned load or store, holds the upstream pipeline while it
// is outstanding, and returns aligned, extended load data.
module mem_access #(
    parameter int unsigned TIMEOUT = 255  // REQ cycles without ack before abort; 0 = never
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Valid,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] Rdata2,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] Rdata,
    output logic        AdrErr,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [5:0] OpLb  = 6'h20;
    localparam logic [5:0] OpLh  = 6'h21;
    localparam logic [5:0] OpLw  = 6'h23;
    localparam logic [5:0] OpLbu = 6'h24;
    localparam logic [5:0] OpLhu = 6'h25;
    localparam logic [5:0] OpSb  = 6'h28;
    localparam logic [5:0] OpSh  = 6'h29;
    localparam logic [5:0] OpSw  = 6'h2B;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] rdata_q, rdata_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    logic [5:0]  opcode;
    logic        is_load, is_store, is_mem, misaligned, accept;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    // Only the opcode field matters to this stage.
    logic unused_ins;
    assign unused_ins = ^Ins[25:0];

    // Decode the incoming instruction and decide whether it is accepted this cycle.
    always_comb begin
        opcode     = Ins[31:26];
        is_load    = opcode inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
        is_store   = opcode inside {OpSb, OpSh, OpSw};
        is_mem     = is_load | is_store;
        misaligned = ((opcode inside {OpLh, OpLhu, OpSh}) && Result[0]) ||
                     ((opcode inside {OpLw, OpSw}) && (Result[1:0] != 2'b00));
        accept     = (state_q == StIdle) && Valid && is_mem && !misaligned;
    end

    // Extract and extend the addressed lane of the returned read data.
    always_comb begin
        rd_byte = bus_rdata[{lane_q, 3'b000} +: 8];
        rd_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (op_q)
            OpLb:    load_val = {{24{rd_byte[7]}}, rd_byte};
            OpLbu:   load_val = {24'h0, rd_byte};
            OpLh:    load_val = {{16{rd_half[15]}}, rd_half};
            OpLhu:   load_val = {16'h0, rd_half};
            default: load_val = bus_rdata;
        endcase
    end

    // Next-state logic for the transaction FSM and its registered bus outputs.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        rdata_d     = rdata_q;
        op_d        = op_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StReq;
                    bus_req_d  = 1'b1;
                    bus_we_d   = is_store;
                    bus_addr_d = {Result[31:2], 2'b00};
                    op_d       = opcode;
                    lane_d     = Result[1:0];
                    cnt_d      = '0;
                    err_d      = 1'b0;
                    unique case (opcode)
                        OpSb: begin
                            bus_wdata_d = {4{Rdata2[7:0]}};
                            bus_be_d    = 4'b0001 << Result[1:0];
                        end
                        OpSh: begin
                            bus_wdata_d = {2{Rdata2[15:0]}};
                            bus_be_d    = Result[1] ? 4'b1100 : 4'b0011;
                        end
                        OpSw: begin
                            bus_wdata_d = Rdata2;
                            bus_be_d    = 4'b1111;
                        end
                        default: begin
                            bus_wdata_d = '0;
                            bus_be_d    = 4'b1111;
                        end
                    endcase
                end
            end
            StReq: begin
                if (bus_ack) begin
                    if (!bus_we_q) rdata_d = load_val;
                    bus_req_d = 1'b0;
                    state_d   = StDone;
                end else if ((TIMEOUT != 0) && (cnt_q + 32'd1 == 32'(TIMEOUT))) begin
                    bus_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            rdata_q     <= '0;
            op_q        <= '0;
            lane_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            rdata_q     <= rdata_d;
            op_q        <= op_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    // Output decode.
    always_comb begin
        Stall     = accept || (state_q == StReq);
        Done      = (state_q == StDone);
        BusErr    = (state_q == StDone) && err_q;
        AdrErr    = (state_q == StIdle) && Valid && is_mem && misaligned;
        Rdata     = rdata_q;
        bus_req   = bus_req_q;
        bus_we    = bus_we_q;
        bus_addr  = bus_addr_q;
        bus_wdata = bus_wdata_q;
        bus_be    = bus_be_q;
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus randomized accesses checked
// against a byte-lane reference model.
module tb_mem_access;

    localparam int unsigned TO = 4;

    logic        CLK = 1'b0;
    logic        RST, Valid, bus_ack;
    logic [31:0] Ins, Result, Rdata2, bus_rdata;
    logic        Stall, Done, AdrErr, BusErr, bus_req, bus_we;
    logic [31:0] Rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int total = 0;
    int bad   = 0;
    logic [31:0] rdata_m;

    always #5 CLK = ~CLK;

    mem_access #(.TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .Valid(Valid), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
        .Stall(Stall), .Done(Done), .Rdata(Rdata), .AdrErr(AdrErr), .BusErr(BusErr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---- reference model: access size in bytes, 0 for non-memory ----
    function automatic int size_m(input logic [5:0] op);
        case (op)
            6'h20, 6'h24, 6'h28: return 1;
            6'h21, 6'h25, 6'h29: return 2;
            6'h23, 6'h2B:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit store_m(input logic [5:0] op);
        return op == 6'h28 || op == 6'h29 || op == 6'h2B;
    endfunction

    function automatic logic [3:0] be_m(input logic [5:0] op, input logic [31:0] a);
        int mask;
        if (!store_m(op)) return 4'hF;
        mask = ((1 << size_m(op)) - 1) << int'(a[1:0]);
        return 4'(mask);
    endfunction

    function automatic logic [31:0] wdata_m(input logic [5:0] op, input logic [31:0] d);
        logic [31:0] w = '0;
        if (!store_m(op)) return '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % size_m(op)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] load_m(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v, mask;
        int sz = size_m(op);
        v    = rd >> (8 * int'(a[1:0]));
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = v & mask;
        if ((op == 6'h20 || op == 6'h21) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // One instruction, from presentation in IDLE through return to IDLE.
    task automatic do_access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int delay);
        int  n;
        bit  tmo;
        Ins    = {op, 26'($urandom)};
        Result = a;
        Rdata2 = wd;
        Valid  = 1'b1;
        bus_ack = 1'b0;
        #1;
        if (size_m(op) == 0) begin
            chk("nonmem_stall", 32'(Stall), 0);
            chk("nonmem_adrerr", 32'(AdrErr), 0);
            @(posedge CLK); #1;
            Valid = 1'b0; #1;
            chk("nonmem_req", 32'(bus_req), 0);
            return;
        end
        if ((int'(a[1:0]) % size_m(op)) != 0) begin
            chk("mis_adrerr", 32'(AdrErr), 1);
            chk("mis_stall", 32'(Stall), 0);
            @(posedge CLK); #1;
            Valid = 1'b0; #1;
            chk("mis_req", 32'(bus_req), 0);
            chk("mis_adrerr_clr", 32'(AdrErr), 0);
            chk("mis_rdata", Rdata, rdata_m);
            return;
        end
        chk("acc_stall", 32'(Stall), 1);
        chk("acc_adrerr", 32'(AdrErr), 0);
        tmo = (delay >= int'(TO));
        n   = tmo ? int'(TO) : delay + 1;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            bus_ack   = (i == delay);
            bus_rdata = (i == delay) ? rd : $urandom;
            #1;
            chk("req_req", 32'(bus_req), 1);
            chk("req_stall", 32'(Stall), 1);
            chk("req_done", 32'(Done), 0);
            chk("req_addr", bus_addr, {a[31:2], 2'b00});
            chk("req_we", 32'(bus_we), 32'(store_m(op)));
            chk("req_wdata", bus_wdata, wdata_m(op, wd));
            chk("req_be", 32'(bus_be), 32'(be_m(op, a)));
        end
        @(posedge CLK); #1;
        bus_ack   = 1'b1;  // must be ignored in DONE
        bus_rdata = $urandom;
        if (!store_m(op) && !tmo) rdata_m = load_m(op, a, rd);
        #1;
        chk("done_done", 32'(Done), 1);
        chk("done_stall", 32'(Stall), 0);
        chk("done_buserr", 32'(BusErr), 32'(tmo));
        chk("done_req", 32'(bus_req), 0);
        chk("done_rdata", Rdata, rdata_m);
        @(posedge CLK); #1;
        bus_ack = 1'b0;
        Valid   = 1'b0;
        #1;
        chk("idle_done", 32'(Done), 0);
        chk("idle_req", 32'(bus_req), 0);
        chk("idle_buserr", 32'(BusErr), 0);
        chk("idle_rdata", Rdata, rdata_m);
    endtask

    initial begin
        logic [5:0] ops [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                                 6'h28, 6'h29, 6'h2B, 6'h00, 6'h0F};
        RST = 1'b1; Valid = 1'b0; Ins = '0; Result = '0; Rdata2 = '0;
        bus_ack = 1'b0; bus_rdata = '0; rdata_m = '0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0; #1;
        chk("rst_rdata", Rdata, 0);
        chk("rst_req", 32'(bus_req), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_buserr", 32'(BusErr), 0);
        chk("rst_stall", 32'(Stall), 0);
        chk("rst_be", 32'(bus_be), 0);

        // Directed cases.
        do_access(6'h23, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        chk("lw_value", Rdata, 32'hDEADBEEF);
        do_access(6'h20, 32'h103, 32'h0, 32'h80FFFFFF, 1);
        chk("lb_value", Rdata, 32'hFFFFFF80);
        do_access(6'h24, 32'h103, 32'h0, 32'h80FFFFFF, 0);
        chk("lbu_value", Rdata, 32'h00000080);
        do_access(6'h25, 32'h102, 32'h0, 32'h80011234, 2);
        chk("lhu_value", Rdata, 32'h00008001);
        do_access(6'h28, 32'h21, 32'h12345678, 32'h0, 0);
        do_access(6'h29, 32'h22, 32'h12345678, 32'h0, 1);
        chk("store_keeps_rdata", Rdata, 32'h00008001);
        do_access(6'h23, 32'h102, 32'h0, 32'h0, 0);
        do_access(6'h2B, 32'h40, 32'hA5A5A5A5, 32'h0, 99);
        do_access(6'h00, 32'h0, 32'h0, 32'h0, 0);

        // Reset during the second REQ cycle of an LW; ack arrives afterwards.
        Ins = {6'h23, 26'h0}; Result = 32'h200; Valid = 1'b1; bus_ack = 1'b0; #1;
        chk("rstx_accept", 32'(Stall), 1);
        @(posedge CLK); #1; #1;
        chk("rstx_req1", 32'(bus_req), 1);
        @(posedge CLK); #1; RST = 1'b1; #1;
        chk("rstx_req2", 32'(bus_req), 1);
        @(posedge CLK); #1;
        RST = 1'b0; Valid = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D; #1;
        rdata_m = '0;
        chk("rstx_req_low", 32'(bus_req), 0);
        chk("rstx_rdata", Rdata, 0);
        chk("rstx_done", 32'(Done), 0);
        @(posedge CLK); #1; bus_ack = 1'b0; #1;
        chk("rstx_done2", 32'(Done), 0);
        chk("rstx_req2_low", 32'(bus_req), 0);
        chk("rstx_rdata2", Rdata, 0);

        // Randomized accesses.
        for (int k = 0; k < 40; k++) begin
            do_access(ops[$urandom_range(0, 9)], $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 5)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
